// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-up / shift-down / parallel load, serial taps at
// both ends, 3-state latched parallel output and a frame counter pulsing every WIDTH shifts.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             n_clr,
    input  logic             clk_inh,
    input  logic [1:0]       mode,
    input  logic             ser_up,
    input  logic             ser_dn,
    input  logic [WIDTH-1:0] d,
    input  logic             latch,
    input  logic             n_oe,
    output logic [WIDTH-1:0] q,
    output logic             q_msb,
    output logic             q_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [1:0]       MODE_HOLD = 2'b00;
    localparam logic [1:0]       MODE_UP   = 2'b01;
    localparam logic [1:0]       MODE_DN   = 2'b10;
    localparam logic [1:0]       MODE_LOAD = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_nxt_s;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             frame_r;
    logic             frame_nxt_s;
    logic             shift_s;

    // Next shift-register contents and whether this edge counts as a shift
    always_comb begin
        sr_nxt_s = sr_r;
        shift_s  = 1'b0;
        if (!clk_inh) begin
            case (mode)
                MODE_HOLD: sr_nxt_s = sr_r;
                MODE_UP: begin
                    sr_nxt_s = {sr_r[WIDTH-2:0], ser_up};
                    shift_s  = 1'b1;
                end
                MODE_DN: begin
                    sr_nxt_s = {ser_dn, sr_r[WIDTH-1:1]};
                    shift_s  = 1'b1;
                end
                MODE_LOAD: sr_nxt_s = d;
                default:   sr_nxt_s = sr_r;
            endcase
        end else begin
            sr_nxt_s = sr_r;
        end
    end

    // Frame counter: load clears it, a shift from WIDTH-1 wraps it and raises frame_done
    always_comb begin
        cnt_nxt_s   = cnt_r;
        frame_nxt_s = 1'b0;
        if (!clk_inh && (mode == MODE_LOAD)) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (shift_s) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s   = CNT_ZERO;
                frame_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output latch samples the pre-edge register, like tied shift/storage clocks
    always_comb begin
        if (latch) begin
            out_nxt_s = sr_r;
        end else begin
            out_nxt_s = out_r;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            sr_r    <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            frame_r <= 1'b0;
        end else begin
            sr_r    <= sr_nxt_s;
            out_r   <= out_nxt_s;
            cnt_r   <= cnt_nxt_s;
            frame_r <= frame_nxt_s;
        end
    end

    assign q          = n_oe ? {WIDTH{1'bz}} : out_r;
    assign q_msb      = sr_r[WIDTH-1];
    assign q_lsb      = sr_r[0];
    assign shift_cnt  = cnt_r;
    assign frame_done = frame_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed vector table, mid-frame reset and output-enable
// sequences, then randomized traffic against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             n_clr;
    logic             clk_inh;
    logic [1:0]       mode;
    logic             ser_up;
    logic             ser_dn;
    logic [WIDTH-1:0] d;
    logic             latch;
    logic             n_oe;
    wire  [WIDTH-1:0] q;
    logic             q_msb;
    logic             q_lsb;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk(clk), .n_clr(n_clr), .clk_inh(clk_inh), .mode(mode),
        .ser_up(ser_up), .ser_dn(ser_dn), .d(d), .latch(latch), .n_oe(n_oe),
        .q(q), .q_msb(q_msb), .q_lsb(q_lsb), .shift_cnt(shift_cnt),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [WIDTH-1:0] m_sr;
    logic [WIDTH-1:0] m_out;
    int               m_cnt;
    bit               m_fd;

    typedef struct {
        logic       inh;
        logic [1:0] mode;
        logic       su;
        logic       sd;
        logic [7:0] d;
        logic       lat;
        logic [7:0] eq;
        logic       emsb;
        logic       elsb;
        logic [3:0] ecnt;
        logic       efd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic inh, logic [1:0] md, logic su, logic sd, logic [7:0] dd,
                                logic lat, logic [7:0] eq, logic emsb, logic elsb,
                                logic [3:0] ecnt, logic efd);
        vec_t v;
        v.inh = inh; v.mode = md; v.su = su; v.sd = sd; v.d = dd; v.lat = lat;
        v.eq = eq; v.emsb = emsb; v.elsb = elsb; v.ecnt = ecnt; v.efd = efd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr  = '0;
        m_out = '0;
        m_cnt = 0;
        m_fd  = 1'b0;
    endtask

    // Apply the behavioural rules for one rising edge using the current inputs
    task automatic model_step();
        int v;
        bit shifted;
        v       = int'(m_sr);
        shifted = 1'b0;
        if (latch) m_out = m_sr;
        m_fd = 1'b0;
        if (!clk_inh) begin
            case (mode)
                2'd1: begin v = (v * 2 + int'(ser_up)) % (1 << WIDTH); shifted = 1'b1; end
                2'd2: begin v = v / 2 + int'(ser_dn) * (1 << (WIDTH - 1)); shifted = 1'b1; end
                2'd3: begin v = int'(d); m_cnt = 0; end
                default: ;
            endcase
        end
        m_sr = v[WIDTH-1:0];
        if (shifted) begin
            m_cnt++;
            if (m_cnt == WIDTH) begin
                m_cnt = 0;
                m_fd  = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        if (!n_oe) check({tag, "_q"}, 32'(q), 32'(m_out));
        check({tag, "_msb"}, 32'(q_msb), 32'(m_sr[WIDTH-1]));
        check({tag, "_lsb"}, 32'(q_lsb), 32'(m_sr[0]));
        check({tag, "_cnt"}, 32'(shift_cnt), 32'(m_cnt));
        check({tag, "_fd"},  32'(frame_done), 32'(m_fd));
    endtask

    task automatic drive(input logic inh, input logic [1:0] md, input logic su, input logic sd,
                         input logic [WIDTH-1:0] dd, input logic lat);
        clk_inh = inh; mode = md; ser_up = su; ser_dn = sd; d = dd; latch = lat;
    endtask

    initial begin
        // inh mode su sd d lat | q msb lsb cnt fd
        tbl.push_back(mk(1'b0, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 4'd1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 4'd3, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 4'd4, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd5, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd6, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 4'd7, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 4'd0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd3, 1'b0, 1'b0, 8'h81, 1'b0, 8'hB2, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b0, 4'd1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b0, 4'd2, 1'b0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b0, 4'd3, 1'b0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b0, 4'd3, 1'b0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 4'd3, 1'b0));
        tbl.push_back(mk(1'b0, 2'd3, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd3, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h3C, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1, 4'd0, 1'b0));

        // Reset held across edges with a load+latch pending: nothing may change
        n_clr = 1'b0; n_oe = 1'b0;
        drive(1'b0, 2'd3, 1'b1, 1'b1, 8'hFF, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_q",   32'(q), 32'h0);
        check("rst_msb", 32'(q_msb), 32'h0);
        check("rst_lsb", 32'(q_lsb), 32'h0);
        check("rst_cnt", 32'(shift_cnt), 32'h0);
        check("rst_fd",  32'(frame_done), 32'h0);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_clr = 1'b1;

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].inh, tbl[i].mode, tbl[i].su, tbl[i].sd, tbl[i].d, tbl[i].lat);
            tick();
            check($sformatf("vec%0d_q", i),   32'(q),          32'(tbl[i].eq));
            check($sformatf("vec%0d_msb", i), 32'(q_msb),      32'(tbl[i].emsb));
            check($sformatf("vec%0d_lsb", i), 32'(q_lsb),      32'(tbl[i].elsb));
            check($sformatf("vec%0d_cnt", i), 32'(shift_cnt),  32'(tbl[i].ecnt));
            check($sformatf("vec%0d_fd", i),  32'(frame_done), 32'(tbl[i].efd));
        end

        // Partial frame, then asynchronous clear between edges
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
            check_model("pre_clr");
        end
        n_clr = 1'b0;
        #1;
        model_reset();
        check_model("async_clr");
        #1;
        n_clr = 1'b1;
        for (int i = 1; i <= WIDTH; i++) begin
            drive(1'b0, (i % 2 == 0) ? 2'd2 : 2'd1, 1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            check($sformatf("post_clr_fd%0d", i), 32'(frame_done), (i == WIDTH) ? 32'h1 : 32'h0);
            check_model("post_clr");
        end

        // Output enable: disabled q must not present the latch, and state survives
        drive(1'b0, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_oe = 1'b1;
        #1;
        tests++;
        if (q === 8'hA5) begin
            fails++;
            $display("FAIL oe_hiz: got %h expected high-impedance", q);
        end
        check_model("oe_off");
        n_oe = 1'b0;
        #1;
        check("oe_back_q", 32'(q), 32'hA5);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r       = int'($urandom_range(0, 9));
            clk_inh = ($urandom_range(0, 7) == 0);
            mode    = (r == 0) ? 2'd0 : (r <= 4) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
            ser_up  = 1'($urandom_range(0, 1));
            ser_dn  = 1'($urandom_range(0, 1));
            d       = WIDTH'($urandom);
            latch   = 1'($urandom_range(0, 1));
            n_oe    = ($urandom_range(0, 3) == 0);
            tick();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
